// File: rtl/wb_pkg.sv
// Shared constants and types for the registered write-back stage.
package wb_pkg;

    localparam logic [1:0] WB_SEL_ALU = 2'd0;
    localparam logic [1:0] WB_SEL_MEM = 2'd1;
    localparam logic [1:0] WB_SEL_PC4 = 2'd2;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    typedef enum logic {
        WB_IDLE     = 1'b0,
        WB_WAIT_MEM = 1'b1
    } wb_state_t;

endpackage

// File: rtl/load_extend.sv
// Byte/halfword/word extraction and sign/zero extension of returned load data.
module load_extend
    import wb_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] mem_rdata,
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    output logic [XLEN-1:0] load_val
);

    logic [31:0] word_v;
    logic [15:0] half_v;
    logic [7:0]  byte_v;
    logic        unused_hi;

    // Upper bits of a 64-bit data word never contribute to a load result.
    assign unused_hi = ^mem_rdata;

    always_comb begin
        word_v = mem_rdata[31:0];
        byte_v = word_v[7:0];
        case (addr_lo)
            2'd0:    byte_v = word_v[7:0];
            2'd1:    byte_v = word_v[15:8];
            2'd2:    byte_v = word_v[23:16];
            default: byte_v = word_v[31:24];
        endcase
        half_v = addr_lo[1] ? word_v[31:16] : word_v[15:0];

        // Reserved encodings fall through to a full-word load.
        case (funct3)
            F3_LB:   load_val = XLEN'($signed(byte_v));
            F3_LBU:  load_val = XLEN'(byte_v);
            F3_LH:   load_val = XLEN'($signed(half_v));
            F3_LHU:  load_val = XLEN'(half_v);
            default: load_val = XLEN'($signed(word_v));
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Registered write-back stage: ALU / load / PC+4 select with a variable-latency load wait.
// Optional load extraction is enabled by defining WB_LOAD_EXT_EN.
module wb_stage
    import wb_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RD_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      wb_sel,
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] pc_4,
    input  logic [RD_W-1:0] rd,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            flush,
    output logic            out_valid,
    output logic            rf_we,
    output logic [RD_W-1:0] out_rd,
    output logic [XLEN-1:0] out_data
);

    wb_state_t       state_q, state_d;
    logic            accept;
    logic            load_done;
    logic [RD_W-1:0] ld_rd_q;
    logic [XLEN-1:0] sel_val;
    logic [XLEN-1:0] load_val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= WB_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = WB_IDLE;
        end else begin
            case (state_q)
                WB_IDLE:     if (accept && wb_sel == WB_SEL_MEM) state_d = WB_WAIT_MEM;
                WB_WAIT_MEM: if (mem_rvalid) state_d = WB_IDLE;
                default:     state_d = WB_IDLE;
            endcase
        end
    end

    // flush has priority over both acceptance and returning load data.
    always_comb begin
        in_ready  = 1'b0;
        accept    = 1'b0;
        load_done = 1'b0;
        in_ready  = (state_q == WB_IDLE) && !flush;
        accept    = in_valid && in_ready;
        load_done = (state_q == WB_WAIT_MEM) && mem_rvalid && !flush;
    end

    assign sel_val = (wb_sel == WB_SEL_ALU) ? alu_result : pc_4;

`ifdef WB_LOAD_EXT_EN
    logic [2:0] ld_f3_q;
    logic [1:0] ld_lo_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_f3_q <= 3'd0;
            ld_lo_q <= 2'd0;
        end else if (accept && wb_sel == WB_SEL_MEM) begin
            ld_f3_q <= funct3;
            ld_lo_q <= addr_lo;
        end
    end

    load_extend #(.XLEN(XLEN)) u_load_extend (
        .mem_rdata (mem_rdata),
        .funct3    (ld_f3_q),
        .addr_lo   (ld_lo_q),
        .load_val  (load_val)
    );
`else
    logic unused_ld;
    assign unused_ld = ^{funct3, addr_lo};
    assign load_val  = mem_rdata;
`endif

    // One registered write per instruction; data and rd hold between pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            rf_we     <= 1'b0;
            out_rd    <= RD_W'(0);
            out_data  <= XLEN'(0);
            ld_rd_q   <= RD_W'(0);
        end else begin
            out_valid <= 1'b0;
            rf_we     <= 1'b0;
            if (accept && wb_sel != WB_SEL_MEM) begin
                out_valid <= 1'b1;
                rf_we     <= (rd != RD_W'(0));
                out_rd    <= rd;
                out_data  <= sel_val;
            end else if (load_done) begin
                out_valid <= 1'b1;
                rf_we     <= (ld_rd_q != RD_W'(0));
                out_rd    <= ld_rd_q;
                out_data  <= load_val;
            end
            if (accept && wb_sel == WB_SEL_MEM) ld_rd_q <= rd;
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed test-plan steps then randomized instruction mix.
module tb_wb_stage;

`ifdef WB_LOAD_EXT_EN
    localparam bit EXT_EN = 1'b1;
`else
    localparam bit EXT_EN = 1'b0;
`endif

    logic        clk, rst_n;
    logic        in_valid, in_ready;
    logic [1:0]  wb_sel;
    logic [2:0]  funct3;
    logic [1:0]  addr_lo;
    logic [31:0] alu_result, pc_4, mem_rdata, out_data;
    logic [4:0]  rd, out_rd;
    logic        mem_rvalid, flush, out_valid, rf_we;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_data = 32'd0;
    logic [4:0]  exp_rd   = 5'd0;

    wb_stage #(.XLEN(32), .RD_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .wb_sel(wb_sel), .funct3(funct3), .addr_lo(addr_lo),
        .alu_result(alu_result), .pc_4(pc_4), .rd(rd),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .flush(flush),
        .out_valid(out_valid), .rf_we(rf_we), .out_rd(out_rd), .out_data(out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: load result computed arithmetically from the load rules.
    function automatic logic [31:0] load_model(input logic [2:0] f3, input logic [1:0] lo,
                                               input logic [31:0] w);
        int unsigned b, h;
        logic [31:0] r;
        b = (w >> (8 * int'(lo))) % 256;
        h = (w >> (16 * (int'(lo) / 2))) % 65536;
        r = w;
        if (EXT_EN) begin
            case (f3)
                3'd0:    r = (b >= 128) ? 32'(b) - 32'd256   : 32'(b);
                3'd1:    r = (h >= 32768) ? 32'(h) - 32'd65536 : 32'(h);
                3'd4:    r = 32'(b);
                3'd5:    r = 32'(h);
                default: r = w;
            endcase
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_pulse(input string tag, input logic [4:0] r, input logic [31:0] d);
        chk({tag, "_valid"}, out_valid, 1'b1);
        chk({tag, "_data"}, out_data, d);
        chk({tag, "_rd"}, out_rd, r);
        chk({tag, "_we"}, rf_we, r != 5'd0);
        exp_data = d;
        exp_rd   = r;
    endtask

    task automatic do_op(input logic [1:0] sel, input logic [31:0] alu, input logic [31:0] pc4,
                         input logic [4:0] r);
        in_valid = 1'b1; wb_sel = sel; alu_result = alu; pc_4 = pc4; rd = r; flush = 1'b0;
        funct3 = 3'($urandom); addr_lo = 2'($urandom);
        mem_rvalid = 1'($urandom); mem_rdata = $urandom;
        #1 chk("op_ready", in_ready, 1'b1);
        tick();
        expect_pulse("op", r, (sel == 2'd0) ? alu : pc4);
    endtask

    task automatic idle_chk();
        in_valid = 1'b0; flush = 1'b0; mem_rvalid = 1'($urandom); mem_rdata = $urandom;
        #1 chk("idle_ready", in_ready, 1'b1);
        tick();
        chk("idle_valid", out_valid, 1'b0);
        chk("idle_we", rf_we, 1'b0);
        chk("hold_data", out_data, exp_data);
        chk("hold_rd", out_rd, exp_rd);
    endtask

    task automatic blocked_op();
        in_valid = 1'b1; wb_sel = 2'd0; alu_result = $urandom; rd = 5'd7; flush = 1'b1;
        mem_rvalid = 1'b0;
        #1 chk("flush_ready", in_ready, 1'b0);
        tick();
        chk("flush_novalid", out_valid, 1'b0);
        flush = 1'b0; in_valid = 1'b0;
    endtask

    // Load with wait_n empty cycles before data returns; fl kills it on the data cycle.
    task automatic do_load(input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] w,
                           input logic [4:0] r, input int wait_n, input bit fl);
        in_valid = 1'b1; wb_sel = 2'd1; funct3 = f3; addr_lo = lo; rd = r; flush = 1'b0;
        alu_result = $urandom; pc_4 = $urandom; mem_rvalid = 1'b0; mem_rdata = $urandom;
        #1 chk("ld_ready", in_ready, 1'b1);
        tick();
        chk("ld_accept_novalid", out_valid, 1'b0);
        for (int i = 0; i < wait_n; i++) begin
            in_valid = 1'b1; wb_sel = 2'($urandom_range(0, 3)); rd = 5'($urandom);
            funct3 = 3'($urandom); addr_lo = 2'($urandom); mem_rvalid = 1'b0;
            #1 chk("ld_wait_ready", in_ready, 1'b0);
            tick();
            chk("ld_wait_valid", out_valid, 1'b0);
        end
        in_valid = 1'b1; wb_sel = 2'd0; rd = 5'($urandom); funct3 = 3'($urandom);
        addr_lo = 2'($urandom); mem_rvalid = 1'b1; mem_rdata = w; flush = fl;
        #1 chk("ld_data_ready", in_ready, 1'b0);
        tick();
        in_valid = 1'b0; mem_rvalid = 1'b0; flush = 1'b0;
        if (fl) begin
            chk("ld_flush_valid", out_valid, 1'b0);
            #1 chk("ld_flush_idle", in_ready, 1'b1);
        end else begin
            expect_pulse("ld", r, load_model(f3, lo, w));
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b1; wb_sel = 2'd0; funct3 = 3'd0; addr_lo = 2'd0;
        alu_result = 32'h1234_5678; pc_4 = 32'h40; rd = 5'd9;
        mem_rvalid = 1'b1; mem_rdata = 32'hA5A5_A5A5; flush = 1'b0;
        #2;
        chk("rst_ready", in_ready, 1'b1);
        tick();
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_we", rf_we, 1'b0);
        chk("rst_rd", out_rd, 5'd0);
        chk("rst_data", out_data, 32'd0);
        rst_n = 1'b1;
        in_valid = 1'b0;

        // Back-to-back non-loads
        do_op(2'd0, 32'd15, 32'hDEAD_0000, 5'd3);
        do_op(2'd2, 32'hBAD0_0000, 32'd4, 5'd4);
        do_op(2'd3, 32'h1, 32'h0000_0100, 5'd31);
        idle_chk();

        do_load(3'd0, 2'd2, 32'h0080_0000, 5'd5, 2, 1'b0);
        do_load(3'd5, 2'd2, 32'hBEEF_0000, 5'd6, 0, 1'b0);
        do_load(3'd7, 2'd1, 32'h8765_4321, 5'd7, 1, 1'b0);
        do_load(3'd1, 2'd3, 32'h8001_7FFF, 5'd8, 0, 1'b0);
        idle_chk();

        do_op(2'd0, 32'd20, 32'd0, 5'd0);
        idle_chk();

        do_load(3'd2, 2'd0, 32'hCAFE_F00D, 5'd9, 1, 1'b1);
        idle_chk();
        blocked_op();
        idle_chk();

        // Reset while a load is outstanding drops it.
        in_valid = 1'b1; wb_sel = 2'd1; rd = 5'd10; funct3 = 3'd2; mem_rvalid = 1'b0;
        tick();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk("rst_wait_ready", in_ready, 1'b1);
        chk("rst_wait_data", out_data, 32'd0);
        chk("rst_wait_rd", out_rd, 5'd0);
        exp_data = 32'd0; exp_rd = 5'd0;
        tick();
        rst_n = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_0000;
        tick();
        chk("rst_wait_drop", out_valid, 1'b0);
        mem_rvalid = 1'b0;
        idle_chk();

        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 4))
                0: do_op(2'd0, $urandom, $urandom, 5'($urandom));
                1: do_op(2'($urandom_range(2, 3)), $urandom, $urandom, 5'($urandom));
                2: do_load(3'($urandom), 2'($urandom), $urandom, 5'($urandom),
                           $urandom_range(0, 3), ($urandom_range(0, 5) == 0));
                3: do_load(3'($urandom), 2'($urandom), $urandom, 5'($urandom), 0, 1'b0);
                default: idle_chk();
            endcase
        end
        idle_chk();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
# wb_stage

Registered write-back stage for the 32-bit RISC-V core, successor to the combinational write-back select. It picks the register-file write value from the ALU result, the load data or PC+4, and waits for load data returned over a variable-latency memory handshake. It also extracts and sign/zero-extends byte and halfword loads, then presents one registered write per instruction to the register file.

## Interface
- XLEN, 32, datapath width; 32 or 64.
- RD_W, 5, destination register index width.

- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  instruction presented.
- in_ready  out  1  stage accepts this cycle.
- wb_sel  in  2  0 ALU, 1 memory, 2 PC+4, 3 PC+4 (alias).
- funct3  in  3  load type: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU.
- addr_lo  in  2  load byte offset (alu_result[1:0]).
- alu_result  in  XLEN  ALU value.
- pc_4  in  XLEN  PC+4.
- rd  in  RD_W  destination register.
- mem_rvalid  in  1  load data valid.
- mem_rdata  in  XLEN  load data word.
- flush  in  1  synchronous kill.
- out_valid  out  1  write-back valid.
- rf_we  out  1  out_valid && out_rd != 0.
- out_rd  out  RD_W  registered destination.
- out_data  out  XLEN  registered write value.

## Operation
- The FSM has two states, IDLE and WAIT_MEM. Reset enters IDLE.
- in_ready = (state == IDLE) && !flush. An instruction is accepted when in_valid && in_ready.
- IDLE, accepted instruction with wb_sel != 1: the selected value is registered. out_valid = 1 on the next cycle, and the FSM stays in IDLE.
- IDLE, accepted instruction with wb_sel == 1: rd, funct3 and addr_lo are captured, and the FSM moves to WAIT_MEM. out_valid = 0 on the next cycle.
- WAIT_MEM with mem_rvalid: the extracted value is registered, out_valid = 1 on the next cycle, and the FSM returns to IDLE.
- mem_rvalid received in IDLE is ignored.
- Load extraction:
  - LB and LBU take byte addr_lo.
  - LH and LHU take halfword addr_lo[1]; addr_lo[0] is ignored.
  - LW takes the low 32 bits. For XLEN = 64, the upper bits are sign-extended.
  - Signed loads sign-extend to XLEN; unsigned loads zero-extend.
  - funct3 values 3, 6 and 7 are treated as LW.
- out_valid is a one-cycle pulse per instruction. Outputs other than out_valid hold their value between pulses.
- flush:
  - Forces the FSM to IDLE.
  - Blocks acceptance in the same cycle.
  - Forces out_valid = 0 on the next cycle.
  - If flush and mem_rvalid occur together, flush wins and the data is discarded.

## Timing
- Reset values: out_valid 0, rf_we 0, out_rd 0, out_data 0, state IDLE. in_ready is 1 while rst_n is low.
- Non-load latency is 1 cycle from acceptance to out_valid. Throughput is 1 instruction per cycle.
- Load latency is 1 cycle after the mem_rvalid cycle.
- in_ready is 0 throughout WAIT_MEM, so at most one load is outstanding.
- Reset asserted in WAIT_MEM returns the stage to IDLE immediately, and the pending load is dropped.

## Configuration
- WB_LOAD_EXT_EN defined: byte and halfword extraction is performed as specified above.
- WB_LOAD_EXT_EN undefined: the load value is mem_rdata unchanged, and funct3 and addr_lo are ignored.

## Structure
- Package wb_pkg holds:
  - WB_SEL_ALU, WB_SEL_MEM and WB_SEL_PC4 constants.
  - Load funct3 codes.
  - State enum wb_state_t.
- Sub-module load_extend: combinational extraction of (mem_rdata, funct3, addr_lo) to XLEN. It is instantiated only under WB_LOAD_EXT_EN.

## Test plan
- Reset: hold rst_n = 0 -> all outputs 0, in_ready = 1.
- Back-to-back non-loads: wb_sel 0 with alu_result = 15, rd = 3, then wb_sel 2 with pc_4 = 4, rd = 4 -> out_data is 15 then 4 on consecutive cycles, rf_we = 1 on both.
- Load with wait: wb_sel 1, LB, addr_lo = 2, mem_rdata = 0x0080_0000, with mem_rvalid 3 cycles later -> in_ready = 0 for 3 cycles, then out_data = 0xFFFF_FF80.
- Load extension: LHU, addr_lo = 2, mem_rdata = 0xBEEF_0000 -> out_data = 0x0000_BEEF. LW with funct3 = 7 -> out_data = full word.
- rd = 0: wb_sel 0, alu_result = 20 -> out_valid = 1, rf_we = 0.
- Flush: flush in the same cycle as mem_rvalid while in WAIT_MEM -> no out_valid, FSM in IDLE, in_ready = 1 on the next cycle.
